// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for the 4-bit ALU.
// Latches one request (op + operands), pulses the matching unit's init,
// waits for its result (fixed latency for sum/sub, done handshake for
// mul/div), registers it onto the shared result bus and pulses done.
// Optional build macro: ALU_SEQ_TIMEOUT_EN adds a mul/div WAIT timeout
// that forces result=8'hFF and raises err.
module alu_sequencer #(
    parameter int unsigned FIX_LAT = 2,   // WAIT cycles for sum/sub (1..15)
    parameter int unsigned TIMEOUT = 64   // mul/div WAIT limit (2..255)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic [1:0] op,
    input  logic [3:0] portA,
    input  logic [3:0] portB,
    output logic [3:0] opA,
    output logic [3:0] opB,
    output logic       init_sum,
    output logic       init_res,
    output logic       init_mul,
    output logic       init_div,
    input  logic [7:0] res_sum,
    input  logic [7:0] res_res,
    input  logic [7:0] res_mul,
    input  logic [7:0] res_div,
    input  logic       done_mul,
    input  logic       done_div,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_SUM = 2'b00, OP_SUB = 2'b01,
                              OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

    state_t     state, state_next;
    op_t        op_q;
    logic [3:0] lat_cnt;
    logic [7:0] unit_res;
    logic       unit_done;
    logic       fix_op;
    logic       capture;
`ifdef ALU_SEQ_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       timeout_hit;
    logic       err_q;
`endif

    assign fix_op = (op_q == OP_SUM) || (op_q == OP_SUB);

    // Select the result and done handshake of the unit chosen by the latched op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        unit_res  = res_sum;
        unit_done = 1'b0;
        case (op_q)
            OP_SUM: unit_res = res_sum;
            OP_SUB: unit_res = res_res;
            OP_MUL: begin
                unit_res  = res_mul;
                unit_done = done_mul;
            end
            OP_DIV: begin
                unit_res  = res_div;
                unit_done = done_div;
            end
        endcase
    end

    // State register; synchronous reset returns to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        init_sum   = 1'b0;
        init_res   = 1'b0;
        init_mul   = 1'b0;
        init_div   = 1'b0;
        capture    = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        busy = (state != IDLE);
        done = (state == DONE);
        case (state)
            IDLE: if (init) state_next = START;
            START: begin
                init_sum   = (op_q == OP_SUM);
                init_res   = (op_q == OP_SUB);
                init_mul   = (op_q == OP_MUL);
                init_div   = (op_q == OP_DIV);
                state_next = WAIT;
            end
            WAIT: begin
                if (fix_op) begin
                    if (lat_cnt == 4'd1) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end
                end else if (unit_done) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (to_cnt == 8'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, fixed-latency counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_SUM;
            opA     <= 4'd0;
            opB     <= 4'd0;
            lat_cnt <= 4'd0;
            result  <= 8'h00;
        end else begin
            if (state == IDLE && init) begin
                op_q <= op_t'(op);
                opA  <= portA;
                opB  <= portB;
            end
            if (state == START)
                lat_cnt <= 4'(FIX_LAT);
            else if (state == WAIT && fix_op && lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;
            if (capture)
                result <= unit_res;
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (timeout_hit)
                result <= 8'hFF;
`endif
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    // Count mul/div WAIT cycles; err is sticky until the next START or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 8'd0;
            err_q  <= 1'b0;
        end else if (state == START) begin
            to_cnt <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (state == WAIT && !fix_op) to_cnt <= to_cnt + 8'd1;
            if (timeout_hit)              err_q  <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a cycle table for the sub and
// reset-mid-op scenarios, plus hand-written mul, busy-rejection,
// back-to-back and (with ALU_SEQ_TIMEOUT_EN) timeout sequences.
module tb_alu_sequencer;

    localparam int unsigned TB_FIX_LAT = 2;
`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 64;
`endif
    localparam int PERIOD = TB_FIX_LAT + 3;

    logic       clk = 1'b0;
    logic       rst, init;
    logic [1:0] op;
    logic [3:0] portA, portB, opA, opB;
    logic       init_sum, init_res, init_mul, init_div;
    logic [7:0] res_sum, res_res, res_mul, res_div;
    logic       done_mul, done_div;
    logic       busy, done, err;
    logic [7:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.FIX_LAT(TB_FIX_LAT), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .init(init), .op(op),
        .portA(portA), .portB(portB), .opA(opA), .opB(opB),
        .init_sum(init_sum), .init_res(init_res),
        .init_mul(init_mul), .init_div(init_div),
        .res_sum(res_sum), .res_res(res_res),
        .res_mul(res_mul), .res_div(res_div),
        .done_mul(done_mul), .done_div(done_div),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    typedef struct {
        logic       rst;
        logic       init;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] rs;
        logic [7:0] rr;
        logic       e_busy;
        logic       e_done;
        logic [3:0] e_inits;   // {sum, res, mul, div}
        logic [7:0] e_result;
        logic [3:0] e_opa;
        logic [3:0] e_opb;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample at the falling edge of the current cycle and compare all outputs.
    task automatic expect_out(input string tag, input logic e_busy, input logic e_done,
                              input logic [3:0] e_inits, input logic [7:0] e_result,
                              input logic [3:0] e_opa, input logic [3:0] e_opb,
                              input logic e_err);
        @(negedge clk);
        check({tag, ".busy"},   8'(busy), 8'(e_busy));
        check({tag, ".done"},   8'(done), 8'(e_done));
        check({tag, ".inits"},  8'({init_sum, init_res, init_mul, init_div}), 8'(e_inits));
        check({tag, ".result"}, result, e_result);
        check({tag, ".opA"},    8'(opA), 8'(e_opa));
        check({tag, ".opB"},    8'(opB), 8'(e_opb));
        check({tag, ".err"},    8'(err), 8'(e_err));
    endtask

    initial begin
        // Sub request (cycles 0-5) with init ignored in DONE, then reset mid-WAIT of a sum.
        vecs[0]  = '{1'b0, 1'b1, 2'b01, 4'd9,  4'd3,  8'h00, 8'h06, 1'b0, 1'b0, 4'b0000, 8'h00, 4'd0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 4'd9,  4'd3,  8'h00, 8'h06, 1'b1, 1'b0, 4'b0100, 8'h00, 4'd9, 4'd3};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 4'd9,  4'd3,  8'h00, 8'h06, 1'b1, 1'b0, 4'b0000, 8'h00, 4'd9, 4'd3};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 4'd9,  4'd3,  8'h00, 8'h06, 1'b1, 1'b0, 4'b0000, 8'h00, 4'd9, 4'd3};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 4'd15, 4'd15, 8'h00, 8'h06, 1'b1, 1'b1, 4'b0000, 8'h06, 4'd9, 4'd3};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 4'd15, 4'd15, 8'h00, 8'h06, 1'b0, 1'b0, 4'b0000, 8'h06, 4'd9, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h06, 4'd9, 4'd3};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b1, 1'b0, 4'b1000, 8'h06, 4'd4, 4'd4};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b1, 1'b0, 4'b0000, 8'h06, 4'd4, 4'd4};
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'd0, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'd0, 4'd0};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 4'd4,  4'd4,  8'h08, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00, 4'd0, 4'd0};

        rst = 1'b1; init = 1'b0; op = 2'b00; portA = 4'd0; portB = 4'd0;
        res_sum = 8'h00; res_res = 8'h00; res_mul = 8'h00; res_div = 8'h00;
        done_mul = 1'b0; done_div = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Table: one row per cycle.
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; init = vecs[i].init; op = vecs[i].op;
            portA = vecs[i].a; portB = vecs[i].b;
            res_sum = vecs[i].rs; res_res = vecs[i].rr;
            expect_out($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done,
                       vecs[i].e_inits, vecs[i].e_result, vecs[i].e_opa, vecs[i].e_opb, 1'b0);
            next_cycle();
        end
        rst = 1'b0;

        // Mul: done_mul raised 6 cycles after init_mul; stray done_div ignored.
        init = 1'b1; op = 2'b10; portA = 4'd5; portB = 4'd7; res_mul = 8'h23;
        expect_out("mul.c0", 1'b0, 1'b0, 4'b0000, 8'h00, 4'd0, 4'd0, 1'b0);
        next_cycle(); init = 1'b0;
        expect_out("mul.start", 1'b1, 1'b0, 4'b0010, 8'h00, 4'd5, 4'd7, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            next_cycle();
            done_div = (c == 3);
            expect_out($sformatf("mul.wait%0d", c), 1'b1, 1'b0, 4'b0000, 8'h00, 4'd5, 4'd7, 1'b0);
        end
        next_cycle(); done_div = 1'b0; done_mul = 1'b1;
        expect_out("mul.c7", 1'b1, 1'b0, 4'b0000, 8'h00, 4'd5, 4'd7, 1'b0);
        next_cycle(); done_mul = 1'b0;
        expect_out("mul.done", 1'b1, 1'b1, 4'b0000, 8'h23, 4'd5, 4'd7, 1'b0);
        next_cycle();
        expect_out("mul.idle", 1'b0, 1'b0, 4'b0000, 8'h23, 4'd5, 4'd7, 1'b0);

        // Div with done_div already in START (not captured) and an init pulse in WAIT (ignored).
        next_cycle();
        init = 1'b1; op = 2'b11; portA = 4'd12; portB = 4'd4; res_div = 8'h03;
        expect_out("div.c0", 1'b0, 1'b0, 4'b0000, 8'h23, 4'd5, 4'd7, 1'b0);
        next_cycle(); init = 1'b0; done_div = 1'b1; res_div = 8'hEE;
        expect_out("div.start", 1'b1, 1'b0, 4'b0001, 8'h23, 4'd12, 4'd4, 1'b0);
        next_cycle(); done_div = 1'b0; res_div = 8'h03;
        init = 1'b1; op = 2'b00; portA = 4'd1; portB = 4'd1;
        expect_out("div.c2", 1'b1, 1'b0, 4'b0000, 8'h23, 4'd12, 4'd4, 1'b0);
        next_cycle(); init = 1'b0; done_mul = 1'b1;
        expect_out("div.c3", 1'b1, 1'b0, 4'b0000, 8'h23, 4'd12, 4'd4, 1'b0);
        next_cycle(); done_mul = 1'b0; done_div = 1'b1;
        expect_out("div.c4", 1'b1, 1'b0, 4'b0000, 8'h23, 4'd12, 4'd4, 1'b0);
        next_cycle(); done_div = 1'b0;
        expect_out("div.done", 1'b1, 1'b1, 4'b0000, 8'h03, 4'd12, 4'd4, 1'b0);
        next_cycle();
        expect_out("div.idle", 1'b0, 1'b0, 4'b0000, 8'h03, 4'd12, 4'd4, 1'b0);
        next_cycle();
        expect_out("div.noqueue", 1'b0, 1'b0, 4'b0000, 8'h03, 4'd12, 4'd4, 1'b0);

        // Back-to-back: init held high, a new sum starts every PERIOD cycles.
        next_cycle();
        init = 1'b1; op = 2'b00; portA = 4'd6; portB = 4'd4; res_sum = 8'h0A;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            expect_out($sformatf("b2b.k%0d", k),
                       1'b0 + (k % PERIOD != 0), 1'b0 + (k % PERIOD == PERIOD - 1),
                       (k % PERIOD == 1) ? 4'b1000 : 4'b0000,
                       (k < PERIOD - 1) ? 8'h03 : 8'h0A,
                       (k == 0) ? 4'd12 : 4'd6, (k == 0) ? 4'd4 : 4'd4, 1'b0);
            next_cycle();
        end
        init = 1'b0;
        expect_out("b2b.stop", 1'b0, 1'b0, 4'b0000, 8'h0A, 4'd6, 4'd4, 1'b0);

`ifdef ALU_SEQ_TIMEOUT_EN
        // Timeout: div never answers; DONE after TIMEOUT WAIT cycles with 8'hFF and err.
        next_cycle();
        init = 1'b1; op = 2'b11; portA = 4'd3; portB = 4'd3;
        expect_out("to.c0", 1'b0, 1'b0, 4'b0000, 8'h0A, 4'd6, 4'd4, 1'b0);
        next_cycle(); init = 1'b0;
        expect_out("to.start", 1'b1, 1'b0, 4'b0001, 8'h0A, 4'd3, 4'd3, 1'b0);
        for (int c = 0; c < int'(TB_TIMEOUT); c++) begin
            next_cycle();
            expect_out($sformatf("to.wait%0d", c), 1'b1, 1'b0, 4'b0000, 8'h0A, 4'd3, 4'd3, 1'b0);
        end
        next_cycle();
        expect_out("to.done", 1'b1, 1'b1, 4'b0000, 8'hFF, 4'd3, 4'd3, 1'b1);
        next_cycle();
        init = 1'b1; op = 2'b00; portA = 4'd2; portB = 4'd2; res_sum = 8'h04;
        expect_out("to.hold", 1'b0, 1'b0, 4'b0000, 8'hFF, 4'd3, 4'd3, 1'b1);
        next_cycle(); init = 1'b0;
        @(negedge clk);
        check("to.start2.init_sum", 8'(init_sum), 8'h01);
        next_cycle();
        expect_out("to.clear", 1'b1, 1'b0, 4'b0000, 8'hFF, 4'd2, 4'd2, 1'b0);
        next_cycle();
        next_cycle();
        expect_out("to.sumdone", 1'b1, 1'b1, 4'b0000, 8'h04, 4'd2, 4'd2, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
